// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide RAM port: byte-lane alignment, splitting of
// word-crossing accesses, and load data reassembly with sign/zero extension.
module mem_access_unit #(
    parameter bit MISALIGN_SPLIT = 1'b1,
    localparam int unsigned DW  = 32,
    localparam int unsigned AW  = 32,
    localparam int unsigned WAW = 30,
    localparam int unsigned MW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          resp_valid_o,
    output logic [DW-1:0] resp_rdata_o,
    output logic          resp_err_o,
    output logic          mem_en_n_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [MW-1:0] mem_wr_mask_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_t;

    state_t state, state_next;

    logic           we_q, uns_q, split_q;
    logic [1:0]     size_q, off_q;
    logic [DW-1:0]  wdata_q, lo_q;
    logic [WAW-1:0] waddr_q;

    logic           accept, in_split, in_err, idle;
    logic [2:0]     in_n;
    logic           sel_we;
    logic [1:0]     sel_size, sel_off;
    logic [DW-1:0]  sel_wdata;
    logic [WAW-1:0] sel_waddr;
    logic [MW-1:0]  be4;
    logic [2*MW-1:0] be8;
    logic [2*DW-1:0] wd64;
    logic [DW-1:0]  rd_lo, rd_hi, ld_word, ld_ext;

    logic           ready_d, resp_valid_d, resp_err_d, en_n_d;
    logic [DW-1:0]  rdata_d, wdata_d;
    logic [AW-1:0]  addr_d;
    logic [MW-1:0]  mask_d;

    // Request decode; the accepting cycle works straight from the inputs
    always_comb begin
        idle   = (state == IDLE);
        accept = idle && req_valid_i && req_ready_o;
        case (req_size_i)
            2'b00:   in_n = 3'd1;
            2'b01:   in_n = 3'd2;
            default: in_n = 3'd4;
        endcase
        in_split = (3'(req_addr_i[1:0]) + in_n) > 3'd4;
        in_err   = (req_size_i == 2'b11) || (in_split && !MISALIGN_SPLIT);

        sel_we    = idle ? req_we_i          : we_q;
        sel_size  = idle ? req_size_i        : size_q;
        sel_off   = idle ? req_addr_i[1:0]   : off_q;
        sel_wdata = idle ? req_wdata_i       : wdata_q;
        sel_waddr = idle ? req_addr_i[31:2]  : waddr_q;

        case (sel_size)
            2'b00:   be4 = 4'b0001;
            2'b01:   be4 = 4'b0011;
            default: be4 = 4'b1111;
        endcase
        // Low half feeds the first word, high half the spill into the next word
        be8  = 8'(be4) << sel_off;
        wd64 = 64'(sel_wdata) << {sel_off, 3'b000};
    end

    // Load reassembly: hi is only meaningful for split loads
    always_comb begin
        rd_lo   = split_q ? lo_q : mem_rdata_i;
        rd_hi   = split_q ? mem_rdata_i : '0;
        ld_word = 32'({rd_hi, rd_lo} >> {off_q, 3'b000});
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'b0, ld_word[7:0]}
                                    : {{24{ld_word[7]}}, ld_word[7:0]};
            2'b01:   ld_ext = uns_q ? {16'b0, ld_word[15:0]}
                                    : {{16{ld_word[15]}}, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_next   = state;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = '0;
        en_n_d       = 1'b1;
        mask_d       = '0;
        addr_d       = mem_addr_o;
        wdata_d      = mem_wdata_o;

        case (state)
            IDLE: if (accept) state_next = in_err ? RESP : ACC0;
            ACC0: begin
                if (split_q)   state_next = ACC1;
                else if (we_q) state_next = RESP;
                else           state_next = WAIT;
            end
            ACC1:    state_next = we_q ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        ready_d      = (state_next == IDLE);
        resp_valid_d = (state_next == RESP);
        resp_err_d   = idle && (state_next == RESP);
        if (state == WAIT) rdata_d = ld_ext;

        if (state_next == ACC0) begin
            en_n_d = 1'b0;
            addr_d = {2'b00, sel_waddr};
            if (sel_we) begin
                mask_d  = be8[3:0];
                wdata_d = wd64[31:0];
            end
        end else if (state_next == ACC1) begin
            en_n_d = 1'b0;
            addr_d = {2'b00, sel_waddr + 30'd1};
            if (sel_we) begin
                mask_d  = be8[7:4];
                wdata_d = wd64[63:32];
            end
        end
    end

    // Request latch and first-word capture for split loads
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            split_q <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            lo_q    <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                split_q <= in_split;
                size_q  <= req_size_i;
                off_q   <= req_addr_i[1:0];
                wdata_q <= req_wdata_i;
                waddr_q <= req_addr_i[31:2];
            end
            if (state == ACC1) lo_q <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_o   <= 1'b0;
            resp_valid_o  <= 1'b0;
            resp_rdata_o  <= '0;
            resp_err_o    <= 1'b0;
            mem_en_n_o    <= 1'b1;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            mem_wr_mask_o <= '0;
        end else begin
            req_ready_o   <= ready_d;
            resp_valid_o  <= resp_valid_d;
            resp_rdata_o  <= rdata_d;
            resp_err_o    <= resp_err_d;
            mem_en_n_o    <= en_n_d;
            mem_addr_o    <= addr_d;
            mem_wdata_o   <= wdata_d;
            mem_wr_mask_o <= mask_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1-cycle registered-read RAM model and a
// second instance built without misaligned splitting.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_en_n;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wr_mask;

    logic        ns_valid = 1'b0, ns_we = 1'b0, ns_unsigned = 1'b0;
    logic [1:0]  ns_size = 2'b00;
    logic [31:0] ns_addr = '0, ns_wdata = '0;
    logic        ns_ready, ns_resp_valid, ns_resp_err, ns_mem_en_n;
    logic [31:0] ns_resp_rdata, ns_mem_addr, ns_mem_wdata;
    logic [31:0] ns_mem_rdata = '0;
    logic [3:0]  ns_mem_wr_mask;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] acc_addr [2];
    logic [31:0] acc_mask [2];
    logic [31:0] acc_wdata[2];
    int          n_acc;

    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] ram [256];

    mem_access_unit #(.MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err), .mem_en_n_o(mem_en_n), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wr_mask_o(mem_wr_mask), .mem_rdata_i(mem_rdata)
    );

    mem_access_unit #(.MISALIGN_SPLIT(1'b0)) dut_ns (
        .clk(clk), .reset(reset),
        .req_valid_i(ns_valid), .req_ready_o(ns_ready), .req_we_i(ns_we),
        .req_size_i(ns_size), .req_unsigned_i(ns_unsigned), .req_addr_i(ns_addr),
        .req_wdata_i(ns_wdata), .resp_valid_o(ns_resp_valid), .resp_rdata_o(ns_resp_rdata),
        .resp_err_o(ns_resp_err), .mem_en_n_o(ns_mem_en_n), .mem_addr_o(ns_mem_addr),
        .mem_wdata_o(ns_mem_wdata), .mem_wr_mask_o(ns_mem_wr_mask), .mem_rdata_i(ns_mem_rdata)
    );

    // RAM model: byte-masked write, registered read, indexed by the low address byte
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_idx] <= pre_data;
        end else if (!mem_en_n) begin
            if (mem_wr_mask == 4'b0000) mem_rdata <= ram[mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (mem_wr_mask[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Issue one request, scramble inputs after acceptance, trace RAM cycles until response
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_acc);
        int lat = 0;
        logic [31:0] got_rdata = '0;
        logic got_err = 1'b0;
        wait_ready(tag);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
        req_addr = addr ^ 32'h5A5A_5A57; req_wdata = ~wdata;
        n_acc = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (!mem_en_n) begin
                if (n_acc < 2) begin
                    acc_addr[n_acc]  = mem_addr;
                    acc_mask[n_acc]  = 32'(mem_wr_mask);
                    acc_wdata[n_acc] = mem_wdata;
                end
                n_acc++;
            end
            if (resp_valid) begin
                lat = k; got_rdata = resp_rdata; got_err = resp_err;
            end
        end
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_err"},   32'(got_err), 32'(exp_err));
        check({tag, "_nacc"},  32'(n_acc), 32'(exp_acc));
    endtask

    initial begin
        preload(8'h40, 32'h0);
        preload(8'h41, 32'h0);
        preload(8'hFF, 32'hAABBCCDD);
        preload(8'h00, 32'h11223344);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_en_n", 32'(mem_en_n), 32'd1);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_mask", 32'(mem_wr_mask), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_ready", 32'(req_ready), 32'd1);

        run_req("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hABCDEF89, 2, 32'h0, 1'b0, 1);
        check("st_word_addr", acc_addr[0], 32'h40);
        check("st_word_mask", acc_mask[0], 32'hF);
        check("st_word_wdata", acc_wdata[0], 32'hABCDEF89);
        run_req("ld_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, 32'hABCDEF89, 1'b0, 1);
        check("ld_word_mask", acc_mask[0], 32'h0);

        run_req("st_byte", 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000FF, 2, 32'h0, 1'b0, 1);
        check("st_byte_mask", acc_mask[0], 32'h2);
        check("st_byte_wdata", acc_wdata[0], 32'h0000FF00);
        run_req("ld_sbyte", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 3, 32'hFFFFFFFF, 1'b0, 1);
        run_req("ld_ubyte", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 3, 32'h000000FF, 1'b0, 1);

        run_req("st_split", 1'b1, 2'b10, 1'b0, 32'h103, 32'h11223344, 3, 32'h0, 1'b0, 2);
        check("st_split_a0", acc_addr[0], 32'h40);
        check("st_split_m0", acc_mask[0], 32'h8);
        check("st_split_d0", acc_wdata[0], 32'h44000000);
        check("st_split_a1", acc_addr[1], 32'h41);
        check("st_split_m1", acc_mask[1], 32'h7);
        check("st_split_d1", acc_wdata[1], 32'h00112233);
        run_req("ld_split", 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 4, 32'h11223344, 1'b0, 2);

        preload(8'h40, 32'h80015A5A);
        run_req("ld_shalf", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 3, 32'hFFFF8001, 1'b0, 1);
        run_req("ld_uhalf", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 3, 32'h00008001, 1'b0, 1);

        run_req("bad_size", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0);

        // Misaligned half load on the non-splitting instance
        begin
            int lat = 0;
            int nacc = 0;
            logic got_err = 1'b0;
            logic [31:0] got_rdata = '1;
            @(negedge clk);
            check("ns_ready", 32'(ns_ready), 32'd1);
            ns_valid = 1'b1; ns_size = 2'b01; ns_addr = 32'h103; ns_we = 1'b0;
            @(posedge clk);
            #1 ns_valid = 1'b0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                @(negedge clk);
                if (!ns_mem_en_n) nacc++;
                if (ns_resp_valid) begin
                    lat = k; got_err = ns_resp_err; got_rdata = ns_resp_rdata;
                end
            end
            check("ns_lat", 32'(lat), 32'd1);
            check("ns_err", 32'(got_err), 32'd1);
            check("ns_rdata", got_rdata, 32'h0);
            check("ns_nacc", 32'(nacc), 32'd0);
            check("ns_mask", 32'(ns_mem_wr_mask), 32'd0);
        end

        run_req("ld_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 4, 32'h3344AABB, 1'b0, 2);
        check("ld_wrap_a0", acc_addr[0], 32'h3FFFFFFF);
        check("ld_wrap_a1", acc_addr[1], 32'h00000000);

        // Reset during ACC1 of a split store
        wait_ready("rst_mid");
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h103; req_wdata = 32'h55667788;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_acc0_en", 32'(mem_en_n), 32'd0);
        check("rst_mid_acc0_mask", 32'(mem_wr_mask), 32'h8);
        @(negedge clk);
        check("rst_mid_acc1_en", 32'(mem_en_n), 32'd0);
        check("rst_mid_acc1_addr", mem_addr, 32'h41);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_en_n", 32'(mem_en_n), 32'd1);
        check("rst_mid_mask", 32'(mem_wr_mask), 32'd0);
        check("rst_mid_rvalid", 32'(resp_valid), 32'd0);
        check("rst_mid_ready0", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready1", 32'(req_ready), 32'd1);
        check("rst_mid_rvalid1", 32'(resp_valid), 32'd0);
        run_req("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, 32'h88015A5A, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
